// File: rtl/memory_bank_ctrl.sv
// memory_bank_ctrl: byte-maskable single-port data memory with valid/ready
// request handshake, registered read data and a zero-fill clear sequencer.
// Ports:
//   Clk, Reset     - clock, synchronous active-high reset
//   Valid/Ready    - request handshake (accept on Valid && Ready)
//   R_W, Addr      - 1 = write / 0 = read, word address
//   Din, Be        - write data, per-byte write enables
//   Flush          - start a zero-fill sweep (honoured in IDLE only)
//   Dout           - registered read data, held between reads
//   Dout_Valid     - one-cycle pulse per completed read
//   Err            - one-cycle pulse for an access with Addr >= DEPTH
//   Busy           - clear sweep in progress
module memory_bank_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Valid,
   output logic                    Ready,
   input  logic                    R_W,
   input  logic [ADDR_WIDTH-1:0]   Addr,
   input  logic [DATA_WIDTH-1:0]   Din,
   input  logic [DATA_WIDTH/8-1:0] Be,
   input  logic                    Flush,
   output logic [DATA_WIDTH-1:0]   Dout,
   output logic                    Dout_Valid,
   output logic                    Err,
   output logic                    Busy
);

   localparam int NB = DATA_WIDTH / 8;
   // One extra bit so DEPTH = 2^ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_clr_ptr;
   logic                    r_ready;
   logic                    r_busy;
   logic [DATA_WIDTH-1:0]   r_dout;
   logic                    r_dout_valid;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic w_accept;
   logic w_in_range;
   logic w_clr_wr;

   assign w_accept   = Valid & r_ready & ~Reset;
   assign w_in_range = {1'b0, Addr} < LP_DEPTH;
   // No array writes at all while Reset is high.
   assign w_clr_wr   = (r_state == S_CLEAR) & ~Reset;

   // Storage: no reset, cleared by the sweep instead.
   always_ff @(posedge Clk) begin
      if (w_clr_wr) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_accept && R_W && w_in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (Be[i]) r_mem[Addr][8*i +: 8] <= Din[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_CLEAR;
         r_clr_ptr    <= '0;
         r_ready      <= 1'b0;
         r_busy       <= 1'b1;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         r_err        <= 1'b0;
         if (w_accept) begin
            r_err <= ~w_in_range;
            if (!R_W) begin
               r_dout_valid <= 1'b1;
               r_dout       <= w_in_range ? r_mem[Addr] : '0;
            end
         end
         unique case (r_state)
            S_CLEAR: begin
               // Terminate on the last populated word, never on wrap.
               if (r_clr_ptr == LP_LAST) begin
                  r_clr_ptr <= '0;
                  r_state   <= S_IDLE;
                  r_ready   <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
               end
            end
            S_IDLE: begin
               // A same-cycle request has already been completed above.
               if (Flush) begin
                  r_state   <= S_CLEAR;
                  r_clr_ptr <= '0;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            default: r_state <= S_CLEAR;
         endcase
      end
   end

   assign Ready      = r_ready;
   assign Busy       = r_busy;
   assign Dout       = r_dout;
   assign Dout_Valid = r_dout_valid;
   assign Err        = r_err;

endmodule

// File: doc/memory_bank_ctrl.md
# memory_bank_ctrl

Parametrised, byte-maskable single-port data memory with a valid/ready request handshake, registered read data, and a hardware clear sequencer. It is the next generation of the team's `Memory` block and the standard storage element behind the datapath and load/store unit. On reset or on an explicit flush it zero-fills every word before it accepts traffic, and it flags accesses beyond the populated depth.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 8: width of `Addr`.
- `DATA_WIDTH`, default 32: word width. Must be a multiple of 8.
- `DEPTH`, default 256: number of populated words. Must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`.

**Ports**
- `Clk`  in  1  sole clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Valid`  in  1  request present.
- `Ready`  out  1  block can accept a request this cycle.
- `R_W`  in  1  1 = write, 0 = read.
- `Addr`  in  `ADDR_WIDTH`  word address.
- `Din`  in  `DATA_WIDTH`  write data.
- `Be`  in  `DATA_WIDTH`/8  byte enables. Bit i covers `Din[8i+7:8i]`.
- `Flush`  in  1  single-cycle request to zero-fill the array.
- `Dout`  out  `DATA_WIDTH`  registered read data.
- `Dout_Valid`  out  1  one-cycle pulse: `Dout` carries the result of a read.
- `Err`  out  1  one-cycle pulse: the accepted access had `Addr` ≥ `DEPTH`.
- `Busy`  out  1  clear sweep in progress.

## Operation

- The FSM has two states, CLEAR and IDLE. A counter `clr_ptr` of width `ADDR_WIDTH` drives the sweep.
- **Reset asserted (any state):**
  - Go to CLEAR with `clr_ptr` = 0.
  - `Dout` = 0, `Dout_Valid` = 0, `Err` = 0, `Ready` = 0, `Busy` = 1.
  - The array is not written while `Reset` is high.
- **CLEAR state:**
  - Each cycle with `Reset` low, write 0 to word `clr_ptr` and increment `clr_ptr`.
  - After the write to `DEPTH`-1, go to IDLE.
  - The sweep takes exactly `DEPTH` cycles.
  - `Ready` = 0 and `Busy` = 1 throughout.
  - `Valid` is ignored and not queued; the requester holds the request.
  - `Flush` is ignored.
- **IDLE state:**
  - `Ready` = 1 and `Busy` = 0.
  - A request is accepted when `Valid` && `Ready` at the rising edge.
- **Accepted write, `Addr` < `DEPTH`:**
  - Each byte with its `Be` bit set is updated from `Din`; other bytes are preserved.
  - `Be` = 0 is a legal no-op write.
  - No `Dout_Valid` pulse.
- **Accepted read, `Addr` < `DEPTH`:**
  - `Dout` ← word at `Addr`; `Dout_Valid` pulses. `Be` is ignored.
- **Accepted access, `Addr` ≥ `DEPTH`:**
  - The array is unchanged and `Err` pulses.
  - For a read, `Dout` ← 0 and `Dout_Valid` also pulses.
- `Dout` holds its last value when `Dout_Valid` is low.
- **`Flush` in IDLE:**
  - Any request presented in the same cycle is still accepted and completed normally.
  - The next state is CLEAR with `clr_ptr` = 0, and the full sweep runs again.
- **`Reset` mid-sweep:** the sweep restarts from word 0; no partial-sweep state is retained.
- **`DEPTH` = 2^`ADDR_WIDTH`:** `Err` can never assert. `clr_ptr` termination is detected by comparing against `DEPTH`-1, never by counter overflow.

## Timing

- Throughput: one request per cycle in IDLE; back-to-back requests are allowed.
- Read latency: a read accepted at edge N drives `Dout`/`Dout_Valid` from edge N until edge N+1.
- Write-then-read: a write accepted at edge N is visible to a read accepted at edge N+1 (no stale data).
- Reset release:
  - `Reset` sampled low first at edge R.
  - `Ready` rises after edge R+`DEPTH`-1, so the first acceptance is at edge R+`DEPTH`.
- Flush:
  - Flush sampled at edge F gives `Ready` = 0 from edge F.
  - `Ready` = 1 again after edge F+`DEPTH`.
- `Err` has the same cycle timing as `Dout_Valid` would have for that access.
- Output reset values: `Dout` = 0, `Dout_Valid` = 0, `Err` = 0, `Ready` = 0, `Busy` = 1.

## Test plan

All scenarios use `ADDR_WIDTH` = 4, `DATA_WIDTH` = 32, `DEPTH` = 12 unless noted.

1. **Reset sweep:** hold `Reset` 2 cycles then release, with `Valid` = 1 throughout -> `Ready` stays 0 for exactly 12 cycles; first read of `Addr` 5 returns 0x00000000 with `Dout_Valid` pulsing 1 cycle.
2. **Write/read-back:** write 0xAABBCCDD to `Addr` 0 with `Be` = 4'hF, then read `Addr` 0 on the next cycle -> `Dout` = 0xAABBCCDD one cycle after the read is accepted.
3. **Byte mask:** over 0xAABBCCDD at `Addr` 0, write `Din` = 0x11223344 with `Be` = 4'b0101, then read -> 0xAA22CC44.
4. **Back-to-back and out of range:**
   - Writes: 0x11223344 to `Addr` 1, 0x55667788 to `Addr` 2, 0x99AABBCC to `Addr` 3.
   - Reads: 3, 2, 1, then 13.
   - Expect `Dout` 0x99AABBCC, 0x55667788, 0x11223344 on consecutive cycles, then 0 with `Err` = 1.
   - A write to `Addr` 13 leaves `Addr` 1 (13 mod 12) unchanged.
5. **Flush:**
   - Pulse `Flush` together with a write of 0xDEADBEEF to `Addr` 4.
   - Expect `Busy` high for 12 cycles, then a read of `Addr` 4 returns 0.
6. **Reset mid-sweep:**
   - Assert `Reset` at sweep cycle 6 for 1 cycle.
   - Expect the sweep to restart, with `Ready` low for a further 12 cycles after release.
   - Repeat with `DEPTH` = 16: `Err` never asserts, and `Addr` 15 is cleared and writable.
